bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
//  Sits directly upstream of the per-digit 7-segment decoders and feeds each of them a 4-bit BCD digit.
//  Uses a start/busy/done handshake, so a counter or ALU result can be shown in decimal.
// PARAMETERS
//  BIN_W   8   width of the unsigned binary input (>=1)
//  DIGITS  3   number of BCD output digits (>=1); bcd_out width = 4*DIGITS
// PORTS
//  clk      in   1          single clock, rising edge
//  rst      in   1          synchronous, active-high reset
//  start    in   1          request a conversion; sampled only in IDLE
//  bin_in   in   BIN_W      unsigned value; captured on the edge that accepts start
//  busy     out  1          high in SHIFT and DONE (state != IDLE)
//  done     out  1          one-cycle pulse: bcd_out/ovf just updated
//  bcd_out  out  4*DIGITS   packed digits; [3:0] = units, [7:4] = tens, ...
//  ovf      out  1          result did not fit: bin_in >= 10**DIGITS
// BEHAVIOUR
//  - Reset (rst=1 at a rising edge): state=IDLE, bcd_out=0, ovf=0, done=0, busy=0, scratch/counter cleared.
//    Reset overrides every other input.
//  - Reset mid-conversion: the conversion is aborted with no done pulse, and outputs take the reset values.
//  - FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE, start=1: latch bin_in into shift reg, clear BCD scratch and ovf_acc, set bit counter=BIN_W, go SHIFT.
//  - IDLE, start=0: hold; bcd_out/ovf keep the last result.
//  - SHIFT, each edge:
//    - every scratch digit >=5 gets +3 (4-bit, no carry between digits);
//    - then shift {scratch,binreg} left by 1;
//    - ovf_acc |= bit shifted out of the top digit;
//    - counter-1.
//  - SHIFT exit: after BIN_W shift edges, the next edge loads bcd_out<=scratch and ovf<=ovf_acc,
//    sets done=1 and moves to DONE.
//  - DONE: done=1 for exactly this cycle; next edge -> IDLE with done=0.
//  - Latency: start sampled at edge E0; done visible after edge E0+BIN_W+1.
//    Minimum start-to-start period is BIN_W+3 edges.
//  - start while busy (SHIFT or DONE) is ignored, not queued; bin_in changes while busy have no effect.
//  - Overflow: bits above the top digit are lost. bcd_out = bin_in mod 10**DIGITS and ovf=1.
//    Lower digits stay correct.
//  - Edge values: bin_in=0 -> all-zero digits.
//    bin_in=2**BIN_W-1 is exact when 10**DIGITS > 2**BIN_W-1.
//  - Every digit of bcd_out is always 0..9 (no illegal BCD codes).
//  - Counter width is $clog2(BIN_W+1); wrap-around never occurs.
// STRUCTURE
//  - Shared package (bcd_pkg):
//    - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
//    - BCD_W=4;
//    - add-3 threshold constant 4'd5.
//  - Sub-module bcd_digit_adj: combinational, 4-bit in -> (in>=5 ? in+3 : in).
//    Instantiated DIGITS times via generate.
//  - Unused state 2'd3 decodes to IDLE on the next edge.
//  - All outputs are registered except busy, which is decoded from the state register.
// TESTING
//  1. Reset, then start=1 for 1 cycle with bin_in=8'd0.
//     -> busy high 10 cycles; done pulse after edge E0+9; bcd_out=12'h000; ovf=0.
//  2. bin_in=8'd255 -> bcd_out=12'h255, ovf=0, done exactly 1 cycle wide.
//     bin_in=8'd109 -> 12'h109.
//  3. DIGITS=2 build, bin_in=8'd123 -> bcd_out=8'h23, ovf=1. Then bin_in=8'd99 -> 8'h99, ovf=0.
//  4. Start 8'd42; pulse start with bin_in=8'd200 at cycles 3 and 10.
//     -> one done only, bcd_out=12'h042.
//  5. Start 8'd77, assert rst at the 4th SHIFT cycle.
//     -> next cycle busy=0, done=0, bcd_out=0, and no done ever appears.
//     Then start 8'd99 -> 12'h099.
//  6. Hold start=1 continuously with bin_in ramping.
//     -> done every 11 cycles; each bcd_out matches the bin_in captured at its accept edge.
//     Scoreboard checks all 0..255 exhaustively.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter:
// state encoding, digit width and the add-3 correction threshold.
package bcd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int BCD_W = 4;

    // Digits at or above this value overflow past 9 when doubled,
    // so they receive +3 before the shift.
    localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational add-3 correction for one BCD digit of the double-dabble scratch.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    output logic [BCD_W-1:0] o_digit
);

    // Pre-correct so that the following left shift carries into the next digit.
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= ADD3_THRESH) begin
            o_digit = i_digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | waiting for start; bcd_out/ovf hold the last result
//  S_SHIFT | adjust-and-shift BIN_W times, then publish result and pulse done
//  S_DONE  | done is high for this single cycle; returns to S_IDLE
//
// Bits carried out of the top digit are dropped, leaving the result modulo
// 10**DIGITS; any such carry sets ovf.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] bcd_out,
    output logic                    ovf
);

    localparam int SCR_W = BCD_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             r_state;
    logic [BIN_W-1:0]   r_bin;
    logic [SCR_W-1:0]   r_scr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_acc;
    logic [SCR_W-1:0]   r_bcd;
    logic               r_ovf;
    logic               r_done;

    state_t             w_state_nxt;
    logic [BIN_W-1:0]   w_bin_nxt;
    logic [SCR_W-1:0]   w_scr_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_ovf_acc_nxt;
    logic [SCR_W-1:0]   w_bcd_nxt;
    logic               w_ovf_nxt;
    logic               w_done_nxt;
    logic [SCR_W-1:0]   w_adj;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scr[g*BCD_W +: BCD_W]),
            .o_digit (w_adj[g*BCD_W +: BCD_W])
        );
    end

    // State and datapath registers; reset clears everything and aborts a conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bin     <= '0;
            r_scr     <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bin     <= w_bin_nxt;
            r_scr     <= w_scr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ovf_acc <= w_ovf_acc_nxt;
            r_bcd     <= w_bcd_nxt;
            r_ovf     <= w_ovf_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state and next-datapath decode; the counter runs down to a terminal count of zero.
    always_comb begin
        w_state_nxt   = r_state;
        w_bin_nxt     = r_bin;
        w_scr_nxt     = r_scr;
        w_cnt_nxt     = r_cnt;
        w_ovf_acc_nxt = r_ovf_acc;
        w_bcd_nxt     = r_bcd;
        w_ovf_nxt     = r_ovf;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_bin_nxt     = bin_in;
                    w_scr_nxt     = '0;
                    w_ovf_acc_nxt = 1'b0;
                    w_cnt_nxt     = CNT_W'(BIN_W);
                    w_state_nxt   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == '0) begin
                    w_bcd_nxt   = r_scr;
                    w_ovf_nxt   = r_ovf_acc;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_scr_nxt     = {w_adj[SCR_W-2:0], r_bin[BIN_W-1]};
                    w_bin_nxt     = r_bin << 1;
                    w_ovf_acc_nxt = r_ovf_acc | w_adj[SCR_W-1];
                    w_cnt_nxt     = r_cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign bcd_out = r_bcd;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: a 3-digit and a 2-digit converter share stimulus; a
// cycle model of the handshake predicts busy/done and queues expected results.
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy,  done,  ovf;
    logic [11:0] bcd_out;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;

    int          n_cmp = 0;
    int          n_err = 0;
    int          m_cnt = 0;
    bit          acc   = 1'b0;
    logic [12:0] q3[$];
    logic [12:0] q2[$];

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
    );

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .ovf(ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Arithmetic reference: {ovf, packed digits of v mod 10**d}.
    function automatic logic [12:0] model_bcd(input int v, input int d);
        int lim = 1;
        int r;
        logic [11:0] b = '0;
        for (int i = 0; i < d; i++) lim *= 10;
        r = v % lim;
        for (int i = 0; i < d; i++) begin
            b[i*4 +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return {(v >= lim), b};
    endfunction

    // One clock: update the handshake model with the inputs present at the edge,
    // then check both DUTs 1 time unit after the edge.
    task automatic tick();
        logic [12:0] e;
        acc = 1'b0;
        if (rst) begin
            m_cnt = 0;
            q3.delete();
            q2.delete();
        end else if (m_cnt == 0) begin
            if (start) begin
                q3.push_back(model_bcd(int'(bin_in), 3));
                q2.push_back(model_bcd(int'(bin_in), 2));
                m_cnt = BIN_W + 2;
                acc = 1'b1;
            end
        end else begin
            m_cnt--;
        end
        @(posedge clk);
        #1;
        chk("busy",  busy,  m_cnt != 0);
        chk("done",  done,  m_cnt == 1);
        chk("busy2", busy2, m_cnt != 0);
        chk("done2", done2, m_cnt == 1);
        if (done) begin
            if (q3.size() == 0) chk("sb3_empty", 1, 0);
            else begin
                e = q3.pop_front();
                chk("bcd3", bcd_out, e[11:0]);
                chk("ovf3", ovf, e[12]);
            end
        end
        if (done2) begin
            if (q2.size() == 0) chk("sb2_empty", 1, 0);
            else begin
                e = q2.pop_front();
                chk("bcd2", bcd2, e[7:0]);
                chk("ovf2", ovf2, e[12]);
            end
        end
        for (int d = 0; d < 3; d++) chk("digit_legal", bcd_out[d*4 +: 4] <= 4'd9, 1);
    endtask

    task automatic run_conv(input logic [7:0] v);
        bit got_acc = 1'b0;
        bin_in = v;
        start  = 1'b1;
        for (int i = 0; i < 20 && !got_acc; i++) begin
            tick();
            got_acc = acc;
        end
        if (!got_acc) chk("accept_timeout", 0, 1);
        start = 1'b0;
        repeat (BIN_W + 2) tick();
    endtask

    initial begin
        int bc;
        int dcount;
        bit got_acc;

        rst = 1'b1; start = 1'b0; bin_in = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_bcd",  bcd_out, 0);
        chk("rst_ovf",  ovf,     0);
        chk("rst_busy", busy,    0);
        chk("rst_done", done,    0);

        // zero input, busy length
        bin_in = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        bc = int'(busy);
        repeat (BIN_W + 2) begin tick(); bc += int'(busy); end
        chk("t1_busy_len", bc, 10);
        chk("t1_bcd", bcd_out, 12'h000);
        chk("t1_sb_drained", q3.size(), 0);

        run_conv(8'd255);
        chk("t2_255", bcd_out, 12'h255);
        chk("t2_255_ovf", ovf, 0);
        run_conv(8'd109);
        chk("t2_109", bcd_out, 12'h109);
        run_conv(8'd123);
        chk("t3_bcd2_123", bcd2, 8'h23);
        chk("t3_ovf2_123", ovf2, 1);
        chk("t3_bcd3_123", bcd_out, 12'h123);
        run_conv(8'd99);
        chk("t3_bcd2_99", bcd2, 8'h99);
        chk("t3_ovf2_99", ovf2, 0);

        // start and bin_in activity while busy must be ignored
        bin_in = 8'd42; start = 1'b1;
        tick();
        start = 1'b0;
        dcount = 0;
        for (int k = 1; k <= 14; k++) begin
            start  = (k == 3 || k == 10);
            bin_in = start ? 8'd200 : 8'($urandom_range(0, 255));
            tick();
            dcount += int'(done);
        end
        start = 1'b0;
        chk("t4_one_done", dcount, 1);
        chk("t4_bcd", bcd_out, 12'h042);

        // reset in the middle of a conversion
        bin_in = 8'd77; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_bcd",  bcd_out, 0);
        dcount = 0;
        repeat (15) begin tick(); dcount += int'(done); end
        chk("t5_no_done", dcount, 0);
        run_conv(8'd99);
        chk("t5_bcd_99", bcd_out, 12'h099);

        // back-to-back with start held: every value 0..255, junk on bin_in while busy
        start = 1'b1;
        for (int v = 0; v < 256; v++) begin
            got_acc = 1'b0;
            for (int i = 0; i < 20 && !got_acc; i++) begin
                bin_in = (m_cnt == 0) ? 8'(v) : 8'($urandom_range(0, 255));
                tick();
                got_acc = acc;
            end
            if (!got_acc) chk("t6_accept_timeout", 0, 1);
        end
        start = 1'b0;
        repeat (BIN_W + 4) tick();
        chk("t6_sb3_drained", q3.size(), 0);
        chk("t6_sb2_drained", q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
